// File: rtl/dh_modexp_if.sv
// dh_modexp_if: operand/result handshake between a DH party and its modexp engine
interface dh_modexp_if #(parameter int WIDTH = 32);
  logic start;
  logic [WIDTH-1:0] base;
  logic [WIDTH-1:0] exponent;
  logic [WIDTH-1:0] modulus;
  logic busy;
  logic done;
  logic error;
  logic [WIDTH-1:0] result;
  modport master(output start, base, exponent, modulus, input busy, done, error, result);
  modport slave(input start, base, exponent, modulus, output busy, done, error, result);
endinterface

// File: rtl/dh_modexp.sv
// dh_modexp: constant-time right-to-left square-and-multiply, base^exponent mod modulus
module dh_modexp #(parameter int WIDTH = 32) (
  input logic clk,
  input logic rst_n,
  dh_modexp_if.slave io
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam int IW = $clog2(WIDTH);
  localparam int XW = WIDTH + 2;
  typedef enum logic [1:0] {IDLE, MUL, STEP, FIN} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] r_q, r_d, b_q, b_d, e_q, e_d, m_q, m_d;
  logic [WIDTH-1:0] acc_r_q, acc_r_d, acc_b_q, acc_b_d, result_q, result_d;
  logic [CW-1:0] bitcnt_q, bitcnt_d;
  logic [IW-1:0] mulcnt_q, mulcnt_d, idx;
  logic error_q, error_d, mbit;
  // One shift-add step: (2*acc mod m + (add ? addend : 0)) mod m, all operands < m
  function automatic logic [WIDTH-1:0] mac(input logic [WIDTH-1:0] acc, addend, m, input logic add);
    logic [XW-1:0] t;
    t = {2'b0, acc} << 1;
    t = t >= {2'b0, m} ? t - {2'b0, m} : t;
    t = t + (add ? {2'b0, addend} : '0);
    t = t >= {2'b0, m} ? t - {2'b0, m} : t;
    return t[WIDTH-1:0];
  endfunction
  assign idx = IW'(WIDTH - 1) - mulcnt_q;
  assign mbit = b_q[idx];
  always_comb begin
    state_d = state_q;
    r_d = r_q;
    b_d = b_q;
    e_d = e_q;
    m_d = m_q;
    acc_r_d = acc_r_q;
    acc_b_d = acc_b_q;
    result_d = result_q;
    bitcnt_d = bitcnt_q;
    mulcnt_d = mulcnt_q;
    error_d = error_q;
    case (state_q)
      IDLE: if (io.start) begin
        r_d = WIDTH'(1);
        b_d = io.base;
        e_d = io.exponent;
        m_d = io.modulus;
        acc_r_d = '0;
        acc_b_d = '0;
        bitcnt_d = '0;
        mulcnt_d = '0;
        result_d = '0;
        error_d = io.modulus < WIDTH'(2) || io.base >= io.modulus;
        state_d = error_d ? FIN : MUL;
      end
      MUL: begin
        acc_r_d = mac(acc_r_q, r_q, m_q, mbit);
        acc_b_d = mac(acc_b_q, b_q, m_q, mbit);
        mulcnt_d = mulcnt_q + 1'b1;
        state_d = mulcnt_q == IW'(WIDTH - 1) ? STEP : MUL;
      end
      STEP: begin
        r_d = e_q[0] ? acc_r_q : r_q;
        b_d = acc_b_q;
        e_d = e_q >> 1;
        bitcnt_d = bitcnt_q + 1'b1;
        mulcnt_d = '0;
        acc_r_d = '0;
        acc_b_d = '0;
        state_d = bitcnt_q == CW'(WIDTH - 1) ? FIN : MUL;
        result_d = bitcnt_q == CW'(WIDTH - 1) ? r_d : result_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      r_q <= '0;
      b_q <= '0;
      e_q <= '0;
      m_q <= '0;
      acc_r_q <= '0;
      acc_b_q <= '0;
      result_q <= '0;
      bitcnt_q <= '0;
      mulcnt_q <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q <= r_d;
      b_q <= b_d;
      e_q <= e_d;
      m_q <= m_d;
      acc_r_q <= acc_r_d;
      acc_b_q <= acc_b_d;
      result_q <= result_d;
      bitcnt_q <= bitcnt_d;
      mulcnt_q <= mulcnt_d;
      error_q <= error_d;
    end
  end
  assign io.busy = state_q == MUL || state_q == STEP;
  assign io.done = state_q == FIN;
  assign io.error = error_q;
  assign io.result = result_q;
endmodule

// File: doc/dh_modexp.md
Name: dh_modexp

Overview:
- Constant-time modular exponentiation engine: result = base^exponent mod modulus.
- Sits directly upstream of the monitor. Each Diffie-Hellman party instantiates one engine to compute its public value and then the shared key.
- The monitor compares the two parties' shared-key results to drive synced, sync_count and iter_count.
- Algorithm: right-to-left square-and-multiply, using two interleaved shift-add modular multipliers running in parallel.

Parameters:
- WIDTH, 32, bit width of base, exponent, modulus and result.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  reset; asynchronous, active-low (0 = reset).
- start  input  1  request; sampled only in IDLE.
- base  input  WIDTH  base operand; captured on accepted start.
- exponent  input  WIDTH  exponent; captured on accepted start.
- modulus  input  WIDTH  modulus; captured on accepted start.
- busy  output  1  high from the cycle after accept until done.
- done  output  1  one-cycle pulse; result is valid in that cycle and held until next accept.
- error  output  1  set with done when operands are illegal; cleared on next accept.
- result  output  WIDTH  exponentiation result.

Behaviour:
- Reset (rst=0, async): state=IDLE; busy=0, done=0, error=0, result=0; all internal registers cleared. Reset asserted mid-operation aborts immediately; no done is produced.
- States: IDLE, MUL, STEP, FIN.
- IDLE:
  - start=1 captures the operands. Internal registers: r=1, b=base, e=exponent, m=modulus, bitcnt=0, mulcnt=0.
  - Clear error; go to MUL.
  - If modulus<2 or base>=modulus: skip to FIN with error=1 and result=0.
- MUL: runs WIDTH cycles. mulcnt walks multiplier bits MSB first. Two accumulators update in parallel:
  - Multiply: accR = 2*accR mod m, then + r if b[bit], then mod m (computes r*b mod m).
  - Square: accB = 2*accB mod m, then + b if b[bit], then mod m (computes b*b mod m).
  - Each modular reduction is a compare/subtract; no division.
  - Intermediate width WIDTH+2 bits (sum < 3m). After WIDTH cycles go to STEP.
- STEP: 1 cycle.
  - If e[0]=1, r=accR; b=accB always.
  - e shifts right 1; bitcnt++; accumulators cleared.
  - If bitcnt reaches WIDTH go to FIN, else go to MUL.
- Constant time: all WIDTH exponent bits are processed regardless of value. There is no early exit on e==0.
- FIN: result=r (or 0 on error); done=1 for exactly one cycle; busy=0; return to IDLE.
- Latency (legal operands):
  - Done is high in cycle WIDTH*(WIDTH+1)+1 after the accepting edge. For WIDTH=8 that is cycle 73; for WIDTH=32, cycle 1057.
  - Error path: done is high in cycle 1 after the accepting edge.
- start while busy=1 is ignored; operands are not re-sampled.
- start held high in the FIN cycle is not accepted. The earliest re-accept is the cycle after done.
- Edge results:
  - exponent=0 gives result=1 (modulus>=2).
  - base=0 with exponent>0 gives result=0.
  - modulus=2^WIDTH-1 must not overflow the intermediates.

Test Plan:
- WIDTH=8, base=5, exp=6, mod=23 -> done at cycle 73 after accept, result=8, error=0, busy high cycles 1..72.
- WIDTH=8, two engines: A=5^15 mod 23 -> 19. Shared keys 19^6 mod 23 and 8^15 mod 23 -> both 2.
- WIDTH=8, exponent=0, base=7, mod=23 -> result=1 at cycle 73. Base=22, exp=2 -> result=1. Base=0, exp=5 -> result=0.
- WIDTH=8, mod=1 -> error=1, result=0, done in cycle 1. Base=30, mod=23 -> same.
- Start pulsed at cycles 10 and 40 after accept with different operands -> ignored; first result unchanged. Start held through FIN -> next accept only after done.
- rst=0 at cycle 30 of operation -> outputs 0 immediately, no done pulse. New start after release -> correct result.
- WIDTH=32, mod=4294967291, base=2, exp=4294967290 -> result=1 at cycle 1057.
